// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and types for the shared countdown-timer scheduler
package timer_pkg;
  localparam int DIV_1HZ_100M = 100_000_000;
  localparam int NUM_CH_DEF = 4;
  localparam int DUR_W_DEF = 8;
  typedef enum logic {T_IDLE, T_COUNT} tchan_state_t;
  typedef logic [DUR_W_DEF-1:0] dur_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: gated clock-divider producing a registered 1-cycle tick every DIV_COUNT cycles
// Optional macro TIMER_PAUSE_EN adds a pause input that freezes the divider phase.
import timer_pkg::*;
module tick_gen #(
  parameter int DIV_COUNT = DIV_1HZ_100M
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
`ifdef TIMER_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);
  localparam int CW = $clog2(DIV_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);
  logic [CW-1:0] cnt;
  logic hold;
`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == LAST);
    end
  end
endmodule

// File: rtl/shared_timer_sched.sv
// shared_timer_sched: NUM_CH countdown timers sharing one divider tick that runs only while any channel is busy
// Optional macro TIMER_PAUSE_EN adds a pause input that freezes the divider and all countdowns.
import timer_pkg::*;
module shared_timer_sched #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int DIV_COUNT = DIV_1HZ_100M
) (
  input  logic                    clk_in,
  input  logic                    reset,
`ifdef TIMER_PAUSE_EN
  input  logic                    pause,
`endif
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH*DUR_W-1:0] duration,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    tick
);
  logic tk;
  tick_gen #(.DIV_COUNT(DIV_COUNT)) u_tick (
    .clk_in(clk_in),
    .reset(reset),
    .en(|busy),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .tick(tick)
  );
`ifdef TIMER_PAUSE_EN
  assign tk = tick & ~pause;
`else
  assign tk = tick;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tchan_state_t st_q, st_d;
    logic [DUR_W-1:0] rem_q, rem_d, dur;
    logic done_q, done_d;
    assign dur = duration[i*DUR_W +: DUR_W];
    // start outranks cancel and tick; a zero duration expires without counting
    always_comb begin
      st_d = st_q;
      rem_d = rem_q;
      done_d = 1'b0;
      if (start[i]) begin
        rem_d = dur;
        st_d = (dur == '0) ? T_IDLE : T_COUNT;
        done_d = (dur == '0);
      end else if (st_q == T_COUNT && cancel[i]) begin
        st_d = T_IDLE;
      end else if (st_q == T_COUNT && tk) begin
        rem_d = (rem_q > DUR_W'(1)) ? rem_q - 1'b1 : rem_q;
        st_d = (rem_q > DUR_W'(1)) ? T_COUNT : T_IDLE;
        done_d = (rem_q == DUR_W'(1));
      end
    end
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        st_q <= T_IDLE;
        rem_q <= '0;
        done_q <= 1'b0;
      end else begin
        st_q <= st_d;
        rem_q <= rem_d;
        done_q <= done_d;
      end
    end
    assign busy[i] = (st_q == T_COUNT);
    assign done[i] = done_q;
  end
endmodule

// File: tb/tb_shared_timer_sched.sv
// tb_shared_timer_sched: directed scenarios checked every cycle against a tick-arithmetic model
module tb_shared_timer_sched;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int DIV = 4;
  logic clk_in = 0;
  logic reset = 1;
  logic pause = 0;
  logic [NC-1:0] start = '0;
  logic [NC-1:0] cancel = '0;
  logic [NC*DW-1:0] duration = '0;
  logic [NC-1:0] busy, done;
  logic tick;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_edge = 0;
  int tick_cnt = 0;
  int done_cnt [NC];
  int done_at [NC];
  int busy_cnt [NC];
  logic [NC-1:0] m_busy, m_done;
  logic m_tick;
  int m_rem [NC];
  int run;

  shared_timer_sched #(.NUM_CH(NC), .DUR_W(DW), .DIV_COUNT(DIV)) dut (
    .clk_in(clk_in),
    .reset(reset),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .start(start),
    .cancel(cancel),
    .duration(duration),
    .busy(busy),
    .done(done),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a channel holds a remaining-tick count; ticks arrive after every DIV enabled, unpaused cycles.
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_busy <= '0;
      m_done <= '0;
      m_tick <= 1'b0;
      run <= 0;
      for (int i = 0; i < NC; i++) m_rem[i] <= 0;
    end else begin
      automatic logic en = |m_busy;
      automatic logic tk = m_tick && !pause;
      automatic int d;
      m_tick <= en && !pause && ((run + 1) % DIV == 0);
      run <= !en ? 0 : (pause ? run : run + 1);
      for (int i = 0; i < NC; i++) begin
        d = int'(duration[i*DW +: DW]);
        if (start[i]) begin
          m_rem[i] <= d;
          m_busy[i] <= (d != 0);
          m_done[i] <= (d == 0);
        end else if (m_busy[i] && cancel[i]) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b0;
        end else if (m_busy[i] && tk) begin
          m_rem[i] <= m_rem[i] - 1;
          m_busy[i] <= (m_rem[i] != 1);
          m_done[i] <= (m_rem[i] == 1);
        end else m_done[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (!reset) begin
      chk("busy_vs_model", int'(busy), int'(m_busy));
      chk("done_vs_model", int'(done), int'(m_done));
      chk("tick_vs_model", int'(tick), int'(m_tick));
      if (tick) tick_cnt++;
      for (int i = 0; i < NC; i++) begin
        if (done[i]) begin
          done_cnt[i]++;
          done_at[i] = cyc;
        end
        if (busy[i]) busy_cnt[i]++;
      end
    end
  end

  task automatic clear_stats();
    tick_cnt = 0;
    for (int i = 0; i < NC; i++) begin
      done_cnt[i] = 0;
      done_at[i] = -1;
      busy_cnt[i] = 0;
    end
  endtask

  // Called at a negedge: present inputs for one edge, return at the following negedge.
  task automatic step(input int ch, input logic st, input logic cn, input int d);
    start[ch] = st;
    cancel[ch] = cn;
    duration[ch*DW +: DW] = DW'(d);
    @(posedge clk_in);
    #1 last_edge = cyc;
    @(negedge clk_in);
    start = '0;
    cancel = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int c0, c2;
    clear_stats();
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_tick", int'(tick), 0);
    idle(3);
    reset = 0;
    idle(2);

    clear_stats();
    step(0, 1, 0, 3);
    c0 = last_edge;
    chk("s1_busy_next", int'(busy[0]), 1);
    idle(20);
    chk("s1_latency", done_at[0] - c0, 13);
    chk("s1_done_cnt", done_cnt[0], 1);
    chk("s1_tick_cnt", tick_cnt, 3);
    chk("s1_idle_busy", int'(busy), 0);

    clear_stats();
    step(1, 1, 0, 0);
    chk("s2_done_next", int'(done[1]), 1);
    idle(6);
    chk("s2_busy_cnt", busy_cnt[1], 0);
    chk("s2_tick_cnt", tick_cnt, 0);
    chk("s2_done_cnt", done_cnt[1], 1);

    clear_stats();
    step(0, 1, 0, 5);
    c0 = last_edge;
    idle(5);
    step(2, 1, 0, 2);
    c2 = last_edge;
    chk("s3_both_busy", int'(busy), 5);
    idle(25);
    chk("s3_ch0_latency", done_at[0] - c0, 21);
    chk("s3_ch2_latency", done_at[2] - c2, 7);
    chk("s3_done_cnt", done_cnt[0] + done_cnt[2], 2);

    clear_stats();
    step(0, 1, 0, 4);
    idle(9);
    step(0, 0, 1, 0);
    chk("s4_cancel_busy", int'(busy[0]), 0);
    idle(12);
    chk("s4_no_done", done_cnt[0], 0);
    chk("s4_tick_cnt", tick_cnt, 2);

    clear_stats();
    step(0, 1, 0, 4);
    idle(4);
    chk("s4_tick_at_reload", int'(tick), 1);
    step(0, 1, 1, 1);
    c0 = last_edge;
    chk("s4_reload_busy", int'(busy[0]), 1);
    idle(10);
    chk("s4_reload_latency", done_at[0] - c0, 4);
    chk("s4_reload_done_cnt", done_cnt[0], 1);

    step(0, 1, 0, 3);
    idle(4);
    #3 reset = 1;
    #1;
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_done", int'(done), 0);
    chk("s5_rst_tick", int'(tick), 0);
    idle(2);
    reset = 0;
    clear_stats();
    idle(10);
    chk("s5_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
    step(0, 1, 0, 3);
    c0 = last_edge;
    idle(20);
    chk("s5_latency", done_at[0] - c0, 13);
    chk("s5_tick_cnt", tick_cnt, 3);

`ifdef TIMER_PAUSE_EN
    clear_stats();
    step(0, 1, 0, 2);
    c0 = last_edge;
    idle(1);
    pause = 1;
    idle(10);
    pause = 0;
    idle(15);
    chk("s6_pause_latency", done_at[0] - c0, 19);
    chk("s6_done_cnt", done_cnt[0], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
